neuron_backprop: RTL and testbench
==================================

Name: neuron_backprop

Overview:
- Backward-pass counterpart of the hidden-layer neuron.
- In TRAIN mode it captures the clipped ReLU activations that the forward neuron emits on its State1 stream, holding them in a small in-order FIFO.
- It later joins each stored activation vector with the error vector returned from the next layer, applies the ReLU derivative gate and saturates the result, then emits a delta vector toward the weight-update and accumulator logic.
- It sits between the forward neuron's State1 output and the backward error network.

Parameters:
- NC, 4, number of neuron lanes per beat.
- WV, 4, activation width (unsigned magnitude held in a signed WV-bit field, range 0..2^(WV-1)-1).
- WE, 8, signed error width per lane.
- WD, 4, signed delta width per lane.
- DEPTH, 4, activation FIFO depth in beats (power of 2, >=2).
- BURST, "yes", "yes" = full-throughput skid behaviour; "no" = half-throughput single register.

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous active-high reset
- iMode  in  1  TRAIN/TEST mode (constants from the shared mode header)
- iValid_AM_State0  in  1  activation beat valid
- oReady_AM_State0  out  1  activation beat ready
- iData_AM_State0  in  NC*WV  activations, lane c at bits [c*WV +: WV]
- iValid_AM_Error0  in  1  error beat valid
- oReady_AM_Error0  out  1  error beat ready
- iData_AM_Error0  in  NC*WE  signed errors, lane c at [c*WE +: WE]
- oValid_BM_Delta0  out  1  delta beat valid
- iReady_BM_Delta0  in  1  delta beat ready
- oData_BM_Delta0  out  NC*WD  signed deltas, lane c at [c*WD +: WD]

Behaviour:
- Reset:
  - FIFO count, read pointer and write pointer all 0.
  - oValid_BM_Delta0=0 and oData_BM_Delta0=0.
  - oReady_AM_Error0=0, because the FIFO is empty.
  - oReady_AM_State0=1 once reset has been released.
  - Reset mid-operation discards all stored beats and the output beat.
- Activation push (TRAIN):
  - A push occurs when iValid_AM_State0 && oReady_AM_State0.
  - With BURST="yes": oReady_AM_State0 = !full || pop (push while full is allowed in the same cycle as a pop).
  - With BURST="no": oReady_AM_State0 = !full.
- Join/pop:
  - fire = !empty && iValid_AM_Error0 && stage_free.
  - oReady_AM_Error0 = !empty && stage_free.
  - A fire pops one activation beat and consumes one error beat in the same cycle, in strict arrival order.
  - An error beat arriving while the FIFO is empty stalls with ready=0 and is never dropped.
- Output stage:
  - BURST="yes": stage_free = !oValid_BM_Delta0 || iReady_BM_Delta0.
  - BURST="no": stage_free = !oValid_BM_Delta0, which gives a bubble every other beat.
  - Latency is 1 cycle from fire to oValid_BM_Delta0=1.
  - Data is held stable while valid && !ready.
  - Valid clears when the beat is taken and no new fire occurs.
- Per-lane arithmetic (registered on fire):
  - If y_c == 0, then d_c = 0 (the ReLU derivative is 0 at and below zero).
  - Otherwise d_c = sat_WD(e_c).
  - sat_WD clamps signed WE to [-2^(WD-1), 2^(WD-1)-1].
  - When WE <= WD, e_c is sign-extended instead.
- Simultaneous events:
  - A push and a pop in the same cycle leave count unchanged.
  - Both pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- TEST mode (iMode=TEST):
  - FIFO is flushed every cycle (count and pointers = 0).
  - oReady_AM_State0=1 and incoming beats are discarded.
  - oReady_AM_Error0=0.
  - The output stage still drains any pending beat.
  - Switching TEST->TRAIN starts from an empty FIFO.

Decomposition:
- Shared header: the TRAIN/TEST mode constants (the existing DECLARE_MODE_PARAMETERS macro) and a saturate-to-WD function macro.
- Sub-module state_fifo:
  - Parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, iCLK, iRST, flush.
  - Synchronous flush; dout is show-ahead (data valid whenever !empty).
- The top level holds the join logic, the gate/saturate datapath and the output register.

Test Plan:
- Reset then idle -> oValid_BM_Delta0=0, oData=0, oReady_AM_State0=1, oReady_AM_Error0=0.
- TRAIN: push activation lanes {3,0,7,1}, then error lanes {5,-4,100,-100} -> one cycle after the join, delta = {5,0,7,-8} with lane 0 first.
- TRAIN: push 4 activation beats (FIFO full) while iReady_BM_Delta0=1:
  - oReady_AM_State0=0 until an error arrives.
  - Then a simultaneous push/pop keeps count at 4.
  - The deltas emerge in push order A0..A3.
- Error valid with FIFO empty for 5 cycles -> oReady_AM_Error0=0 throughout; a later push immediately enables the join on the next cycle.
- BURST="yes": continuous streams with iReady_BM_Delta0 toggled 1,0,1,1 -> no beat lost or duplicated, and data is stable while stalled. BURST="no" -> at most one delta every 2 cycles.
- Assert iRST with 3 beats stored and a pending output, or switch to TEST:
  - Next cycle oValid_BM_Delta0=0 after reset, or the pending beat drains in TEST.
  - FIFO is empty and subsequent errors are not accepted.

Source files
------------

// File: rtl/neuron_backprop_pkg.sv
// Shared definitions for the backward-pass neuron: TRAIN/TEST mode encoding
// and small elaboration-time helpers.
package neuron_backprop_pkg;

    typedef enum logic {
        MODE_TRAIN = 1'b0,
        MODE_TEST  = 1'b1
    } mode_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neuron_backprop_state_fifo.sv
// In-order show-ahead FIFO holding activation beats until their error beat arrives.
// A push into a full FIFO is accepted only in the same cycle as a pop.
module state_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int L_AW = $clog2(DEPTH);

    logic [L_AW-1:0] r_wptr;
    logic [L_AW-1:0] r_rptr;
    logic [L_AW:0]   r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full   = (r_cnt == (L_AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign dout   = r_mem[r_rptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iCLK) begin
        if (iRST || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + L_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (L_AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (L_AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/neuron_backprop.sv
// Backward-pass neuron: joins stored activations with returning errors, gates by
// the ReLU derivative, saturates to the delta width and registers the result.
module neuron_backprop
    import neuron_backprop_pkg::*;
#(
    parameter int    NC    = 4,
    parameter int    WV    = 4,
    parameter int    WE    = 8,
    parameter int    WD    = 4,
    parameter int    DEPTH = 4,
    parameter string BURST = "yes"
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iMode,
    input  logic             iValid_AM_State0,
    output logic             oReady_AM_State0,
    input  logic [NC*WV-1:0] iData_AM_State0,
    input  logic             iValid_AM_Error0,
    output logic             oReady_AM_Error0,
    input  logic [NC*WE-1:0] iData_AM_Error0,
    output logic             oValid_BM_Delta0,
    input  logic             iReady_BM_Delta0,
    output logic [NC*WD-1:0] oData_BM_Delta0
);

    localparam bit L_BURST = (BURST == "yes");
    localparam int L_W     = max_int(WE, WD) + 1;
    localparam logic signed [L_W-1:0] L_DMAX = L_W'((1 << (WD-1)) - 1);
    localparam logic signed [L_W-1:0] L_DMIN = ~L_DMAX;

    // Widening first makes the WE <= WD case a plain sign extension.
    function automatic logic [WD-1:0] f_sat(input logic [WE-1:0] e);
        logic signed [L_W-1:0] v;
        v = L_W'($signed(e));
        if (v > L_DMAX) begin
            return L_DMAX[WD-1:0];
        end
        if (v < L_DMIN) begin
            return L_DMIN[WD-1:0];
        end
        return v[WD-1:0];
    endfunction

    logic             w_train;
    logic             w_full;
    logic             w_empty;
    logic             w_stage_free;
    logic             w_fire;
    logic             w_push;
    logic [NC*WV-1:0] w_act;
    logic [NC*WD-1:0] w_delta;

    logic             r_valid;
    logic [NC*WD-1:0] r_data;

    assign w_train      = (iMode == MODE_TRAIN);
    assign w_stage_free = L_BURST ? (!r_valid || iReady_BM_Delta0) : !r_valid;
    assign w_fire       = w_train && !w_empty && iValid_AM_Error0 && w_stage_free;
    assign w_push       = w_train && iValid_AM_State0 && oReady_AM_State0;

    assign oReady_AM_Error0 = w_train && !w_empty && w_stage_free;
    assign oReady_AM_State0 = !w_train ? 1'b1
                            : (L_BURST ? (!w_full || w_fire) : !w_full);

    state_fifo #(
        .WIDTH (NC*WV),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .flush (!w_train),
        .push  (w_push),
        .pop   (w_fire),
        .din   (iData_AM_State0),
        .dout  (w_act),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_delta = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            if (w_act[c*WV +: WV] != '0) begin
                w_delta[c*WD +: WD] = f_sat(iData_AM_Error0[c*WE +: WE]);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_delta;
        end else if (iReady_BM_Delta0) begin
            r_valid <= 1'b0;
        end
    end

    assign oValid_BM_Delta0 = r_valid;
    assign oData_BM_Delta0  = r_data;

endmodule

// File: tb/tb_neuron_backprop.sv
// Directed bench for neuron_backprop: join/gate/saturate, FIFO ordering and
// back-pressure, reset and TEST flush, plus a half-throughput instance.
module tb_neuron_backprop;
    import neuron_backprop_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        vs, ve, rd;
    logic [15:0] ds;
    logic [31:0] de;
    logic        rdy_s, rdy_e, ov;
    logic [15:0] od;

    logic        vs2, ve2, rd2;
    logic [15:0] ds2;
    logic [31:0] de2;
    logic        rdy_s2, rdy_e2, ov2;
    logic [15:0] od2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [15:0] A [5];
    logic [15:0] D [5];
    logic [31:0] E;

    always #5 clk = ~clk;

    neuron_backprop #(
        .NC(4), .WV(4), .WE(8), .WD(4), .DEPTH(4), .BURST("yes")
    ) u_dut (
        .iCLK             (clk),
        .iRST             (rst),
        .iMode            (mode),
        .iValid_AM_State0 (vs),
        .oReady_AM_State0 (rdy_s),
        .iData_AM_State0  (ds),
        .iValid_AM_Error0 (ve),
        .oReady_AM_Error0 (rdy_e),
        .iData_AM_Error0  (de),
        .oValid_BM_Delta0 (ov),
        .iReady_BM_Delta0 (rd),
        .oData_BM_Delta0  (od)
    );

    neuron_backprop #(
        .NC(4), .WV(4), .WE(8), .WD(4), .DEPTH(4), .BURST("no")
    ) u_dut_nb (
        .iCLK             (clk),
        .iRST             (rst),
        .iMode            (MODE_TRAIN),
        .iValid_AM_State0 (vs2),
        .oReady_AM_State0 (rdy_s2),
        .iData_AM_State0  (ds2),
        .iValid_AM_Error0 (ve2),
        .oReady_AM_Error0 (rdy_e2),
        .iData_AM_Error0  (de2),
        .oValid_BM_Delta0 (ov2),
        .iReady_BM_Delta0 (rd2),
        .oData_BM_Delta0  (od2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Lane k of A[k] is zero, so lane k of D[k] is gated off.
        A[0] = 16'h1110; A[1] = 16'h1101; A[2] = 16'h1011; A[3] = 16'h0111; A[4] = 16'h1111;
        E    = 32'hFF030201;
        D[0] = 16'hF320; D[1] = 16'hF301; D[2] = 16'hF021; D[3] = 16'h0321; D[4] = 16'hF321;

        rst = 1'b1; mode = MODE_TRAIN; vs = 0; ve = 0; rd = 1; ds = '0; de = '0;
        vs2 = 0; ve2 = 0; rd2 = 1; ds2 = '0; de2 = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("reset_valid", ov, 1'b0);
        chk("reset_data", od, 16'h0000);
        chk("reset_rdy_state", rdy_s, 1'b1);
        chk("reset_rdy_err", rdy_e, 1'b0);

        // Single join: y={3,0,7,1}, e={5,-4,100,-100} -> d={5,0,7,-8}
        vs = 1; ds = 16'h1703;
        step();
        vs = 0; ds = '0; #1;
        chk("join_rdy_err", rdy_e, 1'b1);
        chk("join_no_early_valid", ov, 1'b0);
        ve = 1; de = 32'h9C64FC05;
        step();
        ve = 0; #1;
        chk("join_delta", {ov, od}, {1'b1, 16'h8705});
        step();
        chk("join_clear", ov, 1'b0);
        chk("join_empty_rdy_err", rdy_e, 1'b0);

        // Fill to full, then swap one in while popping one out
        for (int k = 0; k < 4; k++) begin
            vs = 1; ds = A[k];
            step();
        end
        ds = A[4]; #1;
        chk("full_rdy_state", rdy_s, 1'b0);
        step();
        chk("full_hold_rdy_state", rdy_s, 1'b0);
        ve = 1; de = E; #1;
        chk("full_pop_rdy_state", rdy_s, 1'b1);
        chk("full_rdy_err", rdy_e, 1'b1);
        step();
        ve = 0; #1;
        chk("swap_still_full", rdy_s, 1'b0);
        chk("swap_delta0", {ov, od}, {1'b1, D[0]});
        vs = 0; ve = 1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("order_delta%0d", k), {ov, od}, {1'b1, D[k]});
        end
        ve = 0;
        step();
        chk("drain_valid", ov, 1'b0);
        chk("drain_rdy_err", rdy_e, 1'b0);

        // Error presented to an empty FIFO must stall, not drop
        ve = 1; de = E;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("starve_rdy_err%0d", i), rdy_e, 1'b0);
        end
        vs = 1; ds = A[4];
        step();
        vs = 0; #1;
        chk("starve_join_rdy", rdy_e, 1'b1);
        step();
        chk("starve_delta", {ov, od}, {1'b1, D[4]});
        ve = 0;
        step();
        chk("starve_clear", ov, 1'b0);

        // Output ready toggled 1,0,1,1 against a continuous error stream
        for (int k = 0; k < 3; k++) begin
            vs = 1; ds = A[k];
            step();
        end
        vs = 0; ve = 1; rd = 1;
        step();
        chk("bp_beat0", {ov, od}, {1'b1, D[0]});
        rd = 0; #1;
        chk("bp_stall_rdy_err", rdy_e, 1'b0);
        step();
        chk("bp_stall_hold", {ov, od}, {1'b1, D[0]});
        rd = 1;
        step();
        chk("bp_beat1", {ov, od}, {1'b1, D[1]});
        step();
        chk("bp_beat2", {ov, od}, {1'b1, D[2]});
        ve = 0;
        step();
        chk("bp_clear", ov, 1'b0);

        // Half-throughput instance: a bubble after every beat
        for (int k = 0; k < 2; k++) begin
            vs2 = 1; ds2 = A[k];
            step();
        end
        vs2 = 0; ve2 = 1; de2 = E;
        step();
        chk("nb_beat0", {ov2, od2}, {1'b1, D[0]});
        chk("nb_busy_rdy_err", rdy_e2, 1'b0);
        step();
        chk("nb_bubble0", ov2, 1'b0);
        step();
        chk("nb_beat1", {ov2, od2}, {1'b1, D[1]});
        step();
        chk("nb_bubble1", ov2, 1'b0);
        ve2 = 0;

        // Reset with three beats stored and one pending output
        rd = 0;
        for (int k = 0; k < 4; k++) begin
            vs = 1; ds = A[k];
            step();
        end
        vs = 0; ve = 1; de = E;
        step();
        chk("rst_pending", {ov, od}, {1'b1, D[0]});
        rst = 1;
        step();
        rst = 0; #1;
        chk("rst_out_cleared", {ov, od}, 17'h0);
        chk("rst_rdy_err", rdy_e, 1'b0);
        chk("rst_rdy_state", rdy_s, 1'b1);
        step();
        chk("rst_no_accept", ov, 1'b0);
        ve = 0;

        // TEST mode with the same setup: pending beat drains, FIFO flushed
        for (int k = 0; k < 4; k++) begin
            vs = 1; ds = A[k];
            step();
        end
        vs = 0; ve = 1;
        step();
        ve = 0;
        mode = MODE_TEST; vs = 1; ds = A[4]; #1;
        chk("test_rdy_err", rdy_e, 1'b0);
        chk("test_rdy_state", rdy_s, 1'b1);
        step();
        chk("test_hold_pending", {ov, od}, {1'b1, D[0]});
        rd = 1;
        step();
        chk("test_drained", ov, 1'b0);
        vs = 0; mode = MODE_TRAIN; ve = 1; #1;
        chk("train_empty_rdy_err", rdy_e, 1'b0);
        step();
        chk("train_no_output", ov, 1'b0);
        ve = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
